// File: rtl/uart_rx_port.sv
// 8N1 UART receiver: oversamples rx, assembles a byte into a holding register,
// and hands it to the CPU with ready/error flags cleared on a rising ack edge.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       arx_ack,
    output logic [7:0] arx_data,
    output logic       arx_ready,
    output logic       arx_busy,
    output logic [1:0] arx_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic [1:0]    err_q, err_d;
    logic          busy_q;
    logic          rx_meta_q, rx_s_q;
    logic          ack_q;

    logic ack_rise;
    logic deliver;
    logic frame_err;

    assign ack_rise = arx_ack & ~ack_q;

    // Frame sequencing: all line decisions use the synchronized rx_s_q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: an ack on the delivery cycle frees the slot in time.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        err_d   = err_q;
        if (ack_rise) begin
            ready_d = 1'b0;
            err_d   = 2'b00;
        end
        if (deliver) begin
            if (!ready_q || ack_rise) begin
                data_d  = shreg_q;
                ready_d = 1'b1;
            end else begin
                err_d[1] = 1'b1;
            end
        end
        if (frame_err) begin
            err_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 2'b00;
            busy_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= (state_d != S_IDLE);
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            ack_q     <= arx_ack;
        end
    end

    assign arx_data  = data_q;
    assign arx_ready = ready_q;
    assign arx_busy  = busy_q;
    assign arx_err   = err_q;

endmodule
